// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS data-memory responder.
//   WORD_W  : data word width (32 bits)
//   BE_W    : byte-enable width (one bit per byte of a word)
//   state_e : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram -- single-port word-addressed storage for the data-memory responder.
// Synchronous write with per-byte enables, combinational read of the same index.
// Contents are never reset.
//   clk     : write clock
//   we_i    : write strobe (one word per cycle)
//   idx_i   : word index for both read and write
//   wdata_i : write data
//   be_i    : byte enables, be_i[0] selects bits 7:0
//   rdata_o : word currently at idx_i
module dmem_sram
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [WORD_W-1:0]              wdata_i,
    input  logic [BE_W-1:0]                be_i,
    output logic [WORD_W-1:0]              rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder -- wait-state data-memory responder for a MIPS core.
// A request seen in IDLE is captured, held for WAIT_CYCLES cycles, then
// answered with a one-cycle ack. Stores commit on the edge that enters RESP.
//   clk, reset          : clock, asynchronous active-low reset
//   req, we, addr,
//   wdata, be           : request from the core (held until ack)
//   rdata               : load data, zero whenever ack is low
//   ack                 : one-cycle completion pulse
//   busy                : a captured request is in flight
//   err                 : only when DMEM_ERR_EN is defined; flags a misaligned
//                         or out-of-range address together with ack
// Define DMEM_ERR_EN to enable address checking; otherwise upper address bits
// wrap and addr[1:0] is ignored.
module mips_dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    output logic              busy
`ifdef DMEM_ERR_EN
   ,output logic              err
`endif
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              ack_q;
    logic              busy_q;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;

    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              addr_err;
    logic              enter_resp;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] rdata_d;

    // With WAIT_CYCLES=0 the commit happens on the capture edge itself, so the
    // access must come straight from the inputs while still in IDLE.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end
    end

`ifdef DMEM_ERR_EN
    assign addr_err = (acc_addr[1:0] != 2'b00) || (acc_addr[WORD_W-1:IDX_W+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[WORD_W-1:IDX_W+2], acc_addr[1:0]};
    assign addr_err         = 1'b0;
`endif

    assign enter_resp = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                        ((state_q == WAIT) && (cnt_q == LAST_CNT));
    assign mem_we     = enter_resp && acc_we && !addr_err;
    assign rdata_d    = (acc_we || addr_err) ? '0 : mem_rdata;

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk     (clk),
        .we_i    (mem_we),
        .idx_i   (acc_addr[IDX_W+1:2]),
        .wdata_i (acc_wdata),
        .be_i    (acc_be),
        .rdata_o (mem_rdata)
    );

    // Request capture; data only, so no reset is needed.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= req;
                    cnt_q   <= 4'd0;
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            rdata_q <= rdata_d;
                            err_q   <= addr_err;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        rdata_q <= rdata_d;
                        err_q   <= addr_err;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
`ifdef DMEM_ERR_EN
    assign err   = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder -- directed bench for mips_dmem_responder.
// Two instances share clock and reset: index 0 uses WAIT_CYCLES=2, index 1
// uses WAIT_CYCLES=0. A timing/memory model predicts ack, busy, rdata (and
// err when DMEM_ERR_EN is defined) on every falling edge.
module tb_mips_dmem_responder;

    localparam int DEPTH = 256;
    localparam int NONE  = -1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       req, we, ack, busy, err;
    logic [1:0][31:0] addr, wdata, rdata;
    logic [1:0][3:0]  be;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0])
`ifdef DMEM_ERR_EN
       ,.err(err[0])
`endif
    );

    mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1])
`ifdef DMEM_ERR_EN
       ,.err(err[1])
`endif
    );

`ifndef DMEM_ERR_EN
    assign err = 2'b00;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int          wc [2] = '{2, 0};
    int          cap[2] = '{NONE, NONE};
    logic        m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_be   [2];
    logic [31:0] mem_m  [2][DEPTH];
    bit          mem_v  [2][DEPTH];

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin : cmp
        for (int d = 0; d < 2; d++) begin
            bit          e_ack, e_busy, known, bad;
            logic [31:0] e_rd;
            int          idx;
            if (!reset) cap[d] = NONE;
            e_busy = reset && (edge_n >= cap[d]) && (edge_n <= cap[d] + wc[d]);
            e_ack  = reset && (edge_n == cap[d] + wc[d]);
            e_rd   = 32'h0;
            known  = 1'b1;
            bad    = 1'b0;
            if (e_ack) begin
                idx = int'((m_addr[d] / 4) % DEPTH);
`ifdef DMEM_ERR_EN
                bad = (m_addr[d] % 4 != 0) || (m_addr[d] >= 32'(4 * DEPTH));
`endif
                if (m_we[d]) begin
                    if (!bad) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[d][b]) mem_m[d][idx][8*b +: 8] = m_wdata[d][8*b +: 8];
                        if (m_be[d] == 4'hF) mem_v[d][idx] = 1'b1;
                    end
                end else if (!bad) begin
                    e_rd  = mem_m[d][idx];
                    known = mem_v[d][idx];
                end
            end
            chk($sformatf("ack[%0d]", d), {31'b0, ack[d]}, {31'b0, e_ack});
            chk($sformatf("busy[%0d]", d), {31'b0, busy[d]}, {31'b0, e_busy});
            if (known) chk($sformatf("rdata[%0d]", d), rdata[d], e_rd);
`ifdef DMEM_ERR_EN
            chk($sformatf("err[%0d]", d), {31'b0, err[d]}, {31'b0, e_ack && bad});
`endif
            // Inputs visible now are sampled at the next rising edge.
            if (reset && req[d] && (edge_n + 1 >= cap[d] + wc[d] + 2)) begin
                cap[d]     = edge_n + 1;
                m_we[d]    = we[d];
                m_addr[d]  = addr[d];
                m_wdata[d] = wdata[d];
                m_be[d]    = be[d];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          output logic [31:0] rd, output int lat, output int ack_edge);
        bit got = 1'b0;
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        lat = 0; rd = 32'hx; ack_edge = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); lat++; #1;
            if (lat == 1) begin
                // scramble everything once captured; the transaction must not notice
                we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd; be[d] = ~b;
            end
            @(negedge clk);
            if (ack[d]) begin
                got = 1'b1; rd = rdata[d]; ack_edge = edge_n;
                break;
            end
        end
        req[d] = 1'b0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    int          lat, e1, e2;

    initial begin
        reset = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", {30'b0, ack}, 32'd0);
            chk("rst_busy", {30'b0, busy}, 32'd0);
            chk("rst_rdata", rdata[0] | rdata[1], 32'd0);
        end
        #70;
        @(posedge clk); #1 reset = 1'b1;

        // WAIT_CYCLES=2 instance
        access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, e1);
        chk("st_lat", 32'(lat), 32'd3);
        chk("st_rdata", rd, 32'h0);
        access(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, e1);
        chk("ld_lat", 32'(lat), 32'd3);
        chk("ld_full", rd, 32'hDEADBEEF);
        access(0, 1, 32'h10, 32'h000000AA, 4'b0001, rd, lat, e1);
        access(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, e1);
        chk("ld_byte0", rd, 32'hDEADBEAA);
        access(0, 1, 32'h4, 32'h01234567, 4'hF, rd, lat, e1);
        access(0, 0, 32'h404, 32'h0, 4'hF, rd, lat, e1);
`ifdef DMEM_ERR_EN
        chk("ld_404_err", rd, 32'h0);
`else
        chk("ld_404_wrap", rd, 32'h01234567);
`endif

        // reset in WAIT aborts the store
        access(0, 1, 32'h20, 32'h11111111, 4'hF, rd, lat, e1);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h22222222; be[0] = 4'hF;
        @(posedge clk); #1;
        chk("abort_busy", {31'b0, busy[0]}, 32'd1);
        reset = 1'b0; req[0] = 1'b0;
        #1 chk("abort_async", {31'b0, busy[0]}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_noack", {31'b0, ack[0]}, 32'd0);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_noack", {31'b0, ack[0]}, 32'd0);
        end
        access(0, 0, 32'h20, 32'h0, 4'h0, rd, lat, e1);
        chk("abort_keep", rd, 32'h11111111);

        // misaligned store
        access(0, 1, 32'h13, 32'h55667788, 4'hF, rd, lat, e1);
        access(0, 0, 32'h10, 32'h0, 4'h0, rd, lat, e1);
`ifdef DMEM_ERR_EN
        chk("st_13_err", rd, 32'hDEADBEAA);
`else
        chk("st_13_wrap", rd, 32'h55667788);
`endif

        // WAIT_CYCLES=0 instance, back-to-back
        access(1, 1, 32'h40, 32'hCAFEF00D, 4'hF, rd, lat, e1);
        chk("w0_lat", 32'(lat), 32'd1);
        access(1, 0, 32'h40, 32'h0, 4'h0, rd, lat, e2);
        chk("w0_b2b", 32'(e2 - e1), 32'd2);
        chk("w0_ld", rd, 32'hCAFEF00D);
        access(1, 1, 32'h40, 32'h11223344, 4'b1010, rd, lat, e1);
        access(1, 0, 32'h40, 32'h0, 4'h0, rd, lat, e2);
        chk("w0_b2b2", 32'(e2 - e1), 32'd2);
        chk("w0_merge", rd, 32'h11FE330D);

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
